midi_uart_rx: RTL and testbench



---
 rtl/midi_uart_rx.sv | 218 +++++++++++++++++++++
 tb/tb_midi_uart_rx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_uart_rx.sv
// -----------------------------------------------------------------------------
// midi_uart_rx
//   Serial receiver for the MIDI input (31250 baud, 8N1, LSB first). The line
//   is resynchronised, oversampled OVS times per bit by a free-running tick
//   divider, and framed by a small FSM. Each correctly framed byte is
//   presented on DATA with a one-clock VALID strobe. A low stop bit gives a
//   one-clock FERR strobe, and the receiver then waits in BRK until the line
//   returns high.
//
//   Optional feature: define MIDI_RX_MAJORITY_EN to decide every start, data
//   and stop bit by a 2-of-3 vote over the ticks mid-1, mid and mid+1. The
//   decision lands one tick later than in the default single-sample build.
//
// Ports
//   CLK    in   system clock, rising edge
//   RST_N  in   synchronous reset, active-low
//   RXD    in   asynchronous serial line, idle high
//   DATA   out  [7:0] last correctly framed byte
//   VALID  out  one-CLK strobe, DATA has just been updated
//   FERR   out  one-CLK strobe, stop bit sampled low
//   BUSY   out  high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module midi_uart_rx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 31250,
  parameter int OVS      = 16,
  parameter int DIV      = CLK_FREQ / (BAUD * OVS),
  parameter int DW       = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       RXD,
  output logic [7:0] DATA,
  output logic       VALID,
  output logic       FERR,
  output logic       BUSY
);

  localparam int PW = $clog2(OVS);

`ifdef MIDI_RX_MAJORITY_EN
  // The vote needs the mid+1 sample, so the start decision moves one tick
  // later. Every later bit inherits that shift through the phase counter.
  localparam int VOTE_LAT = 1;
`else
  localparam int VOTE_LAT = 0;
`endif

  localparam logic [DW-1:0] C_DIV_MAX   = DW'(DIV - 1);
  localparam logic [PW-1:0] C_START_MID = PW'(OVS / 2 - 1 + VOTE_LAT);
  localparam logic [PW-1:0] C_BIT_MID   = PW'(OVS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK
  } state_t;

  logic          r_rx_meta;
  logic          r_rxs;
  logic [DW-1:0] r_div_cnt;
  logic          w_tick;
  logic          w_bit;
  state_t        r_state;
  logic [PW-1:0] r_phase;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_ferr;
  logic          r_busy;

  // Two-flop synchroniser on the asynchronous line.
  // NOTE: these reset to 1 (the idle level). Resetting them to 0 would look
  // like a start edge the moment reset is released.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      // NOTE: non-blocking so that r_rxs takes the old r_rx_meta. This gives
      // two real flop stages rather than one collapsed stage.
      r_rx_meta <= RXD;
      r_rxs     <= r_rx_meta;
    end
  end

  // Free-running oversample divider. It is never re-phased by the line, which
  // bounds start-edge detection jitter to one tick.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_div_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  assign w_tick = (r_div_cnt == C_DIV_MAX);

`ifdef MIDI_RX_MAJORITY_EN
  // History of the two previous tick samples. At a decision tick these hold
  // mid-1 and mid, and r_rxs supplies mid+1.
  logic [1:0] r_smp;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_smp <= 2'b11;
    end else if (w_tick) begin
      r_smp <= {r_smp[0], r_rxs};
    end
  end

  assign w_bit = (r_smp[1] & r_smp[0]) | (r_smp[1] & r_rxs) | (r_smp[0] & r_rxs);
`else
  assign w_bit = r_rxs;
`endif

  // Framing FSM. Everything except the strobe clear advances only on ticks.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_phase <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      // Strobes default low every clock so each pulse is exactly one CLK wide.
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      if (w_tick) begin
        case (r_state)
          S_IDLE: begin
            if (!r_rxs) begin
              r_state <= S_START;
              r_phase <= '0;
              r_busy  <= 1'b1;
            end
          end

          S_START: begin
            if (r_phase == C_START_MID) begin
              if (!w_bit) begin
                r_state <= S_DATA;
                r_phase <= '0;
                r_bit   <= '0;
              end else begin
                // Line was high again at mid start bit, so treat it as a glitch.
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_phase <= r_phase + 1'b1;
            end
          end

          S_DATA: begin
            if (r_phase == C_BIT_MID) begin
              // Right shift: the first (LSB) sample ends up in bit 0.
              r_shift <= {w_bit, r_shift[7:1]};
              r_phase <= '0;
              r_bit   <= r_bit + 1'b1;
              if (r_bit == 3'd7) begin
                r_state <= S_STOP;
              end
            end else begin
              r_phase <= r_phase + 1'b1;
            end
          end

          S_STOP: begin
            if (r_phase == C_BIT_MID) begin
              // IDLE is re-entered at mid stop, so a start edge in the second
              // half of the stop bit is already seen.
              if (w_bit) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_ferr  <= 1'b1;
                r_state <= S_BRK;
              end
            end else begin
              r_phase <= r_phase + 1'b1;
            end
          end

          S_BRK: begin
            // A held-low line (break or unplugged cable) must not produce a
            // stream of frames. Wait for the line to go high first.
            if (r_rxs) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end

          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign DATA  = r_data;
  assign VALID = r_valid;
  assign FERR  = r_ferr;
  assign BUSY  = r_busy;

endmodule

// File: tb/tb_midi_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_midi_uart_rx
//   Self-checking bench for midi_uart_rx. The clock is scaled to 2 MHz so that
//   one bit lasts 64 clocks and one oversample tick lasts 4 clocks. All time
//   intervals are expressed in bit periods, so they keep their meaning at this
//   clock rate.
//
//   The reference model is the serial protocol itself. Every frame sent with a
//   high stop bit is expected to appear once on DATA/VALID, in order. A frame
//   with a low stop bit is expected to give one FERR and leave DATA unchanged.
//   A short start glitch or a reset is expected to give no strobe.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_midi_uart_rx;

  localparam int TB_CLK_FREQ = 2_000_000;
  localparam int TB_BAUD     = 31250;
  localparam int TB_OVS      = 16;
  localparam int TICK_CLKS   = TB_CLK_FREQ / (TB_BAUD * TB_OVS);
  localparam int BIT_CLKS    = TICK_CLKS * TB_OVS;

  logic       CLK;
  logic       RST_N;
  logic       RXD;
  logic [7:0] DATA;
  logic       VALID;
  logic       FERR;
  logic       BUSY;

  midi_uart_rx #(
    .CLK_FREQ(TB_CLK_FREQ),
    .BAUD    (TB_BAUD),
    .OVS     (TB_OVS),
    .DW      (8)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .RXD  (RXD),
    .DATA (DATA),
    .VALID(VALID),
    .FERR (FERR),
    .BUSY (BUSY)
  );

  initial CLK = 1'b0;
  always #250 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Event monitor. It records what the DUT emits. Judgement is left to the
  // main sequence.
  logic [7:0] got_q[$];
  int n_valid = 0;
  int n_ferr  = 0;
  int n_both  = 0;
  int n_wide  = 0;
  logic prev_v = 1'b0;
  logic prev_f = 1'b0;

  always @(negedge CLK) begin
    if (VALID) begin
      got_q.push_back(DATA);
      n_valid++;
    end
    if (FERR) n_ferr++;
    if (VALID && FERR) n_both++;
    if ((VALID && prev_v) || (FERR && prev_f)) n_wide++;
    prev_v = VALID;
    prev_f = FERR;
  end

  // Reference state.
  logic [7:0] exp_q[$];
  logic [7:0] exp_data;
  int exp_ferr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive the line to v for n clocks. The line changes on a negedge.
  task automatic drive(input logic v, input int n);
    RXD = v;
    repeat (n) @(negedge CLK);
  endtask

  // One 8N1 frame. With glitch set, bit 0 is pulled low for one tick,
  // starting at its nominal centre. With chk_busy set, BUSY is checked
  // early in the stop bit and again at the end of the frame.
  task automatic send_frame(input logic [7:0] b, input int bc, input logic stop_v,
                            input logic glitch, input logic chk_busy);
    drive(1'b0, bc);
    for (int i = 0; i < 8; i++) begin
      if (glitch && i == 0) begin
        drive(b[0], bc / 2);
        drive(1'b0, TICK_CLKS);
        drive(b[0], bc - bc / 2 - TICK_CLKS);
      end else begin
        drive(b[i], bc);
      end
    end
    if (chk_busy) begin
      drive(stop_v, bc / 4);
      check("busy_early_stop", BUSY, 1);
      drive(stop_v, bc - bc / 4);
      check("busy_after_mid_stop", BUSY, 0);
    end else begin
      drive(stop_v, bc);
    end
  endtask

  // Good frame: the model expects the byte to be delivered.
  task automatic good_frame(input logic [7:0] b, input int bc);
    send_frame(b, bc, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(b);
    exp_data = b;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_data"},   DATA,    exp_data);
    check({tag, "_nvalid"}, n_valid, exp_q.size());
    check({tag, "_nferr"},  n_ferr,  exp_ferr);
  endtask

  initial begin
    logic [7:0] rb;
    logic [7:0] glitch_exp;
    int gap;
    int bc;

    exp_data = 8'h00;
    exp_ferr = 0;
    RXD      = 1'b1;
    RST_N    = 1'b0;
    repeat (4) @(negedge CLK);
    check("rst_data",  DATA,  8'h00);
    check("rst_valid", VALID, 0);
    check("rst_ferr",  FERR,  0);
    check("rst_busy",  BUSY,  0);
    RST_N = 1'b1;
    drive(1'b1, BIT_CLKS);

    // Single 0x90 frame, with BUSY checked around mid stop.
    send_frame(8'h90, BIT_CLKS, 1'b1, 1'b0, 1'b1);
    exp_q.push_back(8'h90);
    exp_data = 8'h90;
    drive(1'b1, BIT_CLKS);
    check_state("single_90");

    // Three frames back to back, with no idle gap between them.
    send_frame(8'h90, BIT_CLKS, 1'b1, 1'b0, 1'b0);
    send_frame(8'h3C, BIT_CLKS, 1'b1, 1'b0, 1'b0);
    send_frame(8'h7F, BIT_CLKS, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(8'h90);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h7F);
    exp_data = 8'h7F;
    drive(1'b1, BIT_CLKS);
    check_state("b2b");

    // A 4 us low pulse (1/8 bit) is a false start and must be dropped.
    drive(1'b0, TB_CLK_FREQ / 250_000);
    drive(1'b1, 2 * BIT_CLKS);
    check("glitch_busy", BUSY, 0);
    check_state("glitch");

    // Framing error, then a 1 ms break, then recovery.
    good_frame(8'h55, BIT_CLKS);
    drive(1'b1, BIT_CLKS);
    send_frame(8'h3C, BIT_CLKS, 1'b0, 1'b0, 1'b0);
    exp_ferr++;
    drive(1'b0, TB_CLK_FREQ / 1000);
    drive(1'b1, 2 * BIT_CLKS);
    check_state("ferr_break");
    check("ferr_break_busy", BUSY, 0);
    good_frame(8'hA5, BIT_CLKS);
    drive(1'b1, BIT_CLKS);
    check_state("after_break");

    // Reset pulse after 4 data bits of 0xFF.
    drive(1'b0, BIT_CLKS);
    drive(1'b1, 4 * BIT_CLKS);
    check("pre_reset_busy", BUSY, 1);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    exp_data = 8'h00;
    check("post_reset_data", DATA, 8'h00);
    check("post_reset_busy", BUSY, 0);
    drive(1'b1, 6 * BIT_CLKS);
    check_state("after_reset");
    good_frame(8'h45, BIT_CLKS);
    drive(1'b1, BIT_CLKS);
    check_state("post_reset_45");

    // Baud error of about +/-3%.
    good_frame(8'h45, BIT_CLKS - 2);
    drive(1'b1, BIT_CLKS);
    check_state("baud_fast");
    good_frame(8'h45, BIT_CLKS + 2);
    drive(1'b1, BIT_CLKS);
    check_state("baud_slow");

    // One-tick low glitch at the centre of bit 0 of 0x01.
`ifdef MIDI_RX_MAJORITY_EN
    glitch_exp = 8'h01;
`else
    glitch_exp = 8'h00;
`endif
    send_frame(8'h01, BIT_CLKS, 1'b1, 1'b1, 1'b0);
    exp_q.push_back(glitch_exp);
    exp_data = glitch_exp;
    drive(1'b1, BIT_CLKS);
    check_state("mid_glitch");

    // Random bytes, random idle gaps and small baud offsets.
    for (int k = 0; k < 6; k++) begin
      rb  = 8'($urandom_range(0, 255));
      gap = $urandom_range(0, 3);
      bc  = BIT_CLKS - 2 + $urandom_range(0, 4);
      good_frame(rb, bc);
      drive(1'b1, gap * BIT_CLKS + BIT_CLKS);
      check_state("random");
    end

    check("valid_ferr_overlap", n_both, 0);
    check("strobe_width",       n_wide, 0);
    check("byte_count",         got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check("byte_seq", got_q[i], exp_q[i]);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
